// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Latches the decoded operands and controls. It forwards results from EX/MEM and
// MEM/WB into the rs/rt operands, then drives the ALU inputs a, b and aluc.
// It also detects a load-use hazard between the instruction it holds and the
// instruction now in decode.
//
// Ports:
//   clock, resetn         rising-edge clock, synchronous active-low reset
//   stall, flush          hold contents / replace contents with a bubble
//   d_*                   decoded instruction presented by the decode stage
//   m_wreg/m_m2reg/m_rn/m_alu   EX/MEM write-back info for forwarding
//   w_wreg/w_rn/w_data    MEM/WB write-back info for forwarding
//   e_a, e_b, e_aluc      ALU operands and operation code
//   e_store               forwarded rt value (store data)
//   e_valid/e_wreg/e_m2reg/e_wmem/e_rn   registered controls, gated by valid
//   load_use              decode must be held this cycle
module id_ex_stage #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          stall,
  input  logic          flush,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [AW-1:0] d_rn,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic [DW-1:0] d_qa,
  input  logic [DW-1:0] d_qb,
  input  logic [DW-1:0] d_imm,
  input  logic [4:0]    d_sa,
  input  logic [3:0]    d_aluc,
  input  logic          d_aluimm,
  input  logic          d_shift,
  input  logic          d_wreg,
  input  logic          d_m2reg,
  input  logic          d_wmem,
  input  logic          m_wreg,
  input  logic          m_m2reg,
  input  logic [AW-1:0] m_rn,
  input  logic [DW-1:0] m_alu,
  input  logic          w_wreg,
  input  logic [AW-1:0] w_rn,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] e_a,
  output logic [DW-1:0] e_b,
  output logic [3:0]    e_aluc,
  output logic [DW-1:0] e_store,
  output logic          e_valid,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic          e_wmem,
  output logic [AW-1:0] e_rn,
  output logic          load_use
);

  logic          valid_r, aluimm_r, shift_r, wreg_r, m2reg_r, wmem_r;
  logic [AW-1:0] rs_r, rt_r, rn_r;
  logic [DW-1:0] qa_r, qb_r, imm_r;
  logic [4:0]    sa_r;
  logic [3:0]    aluc_r;

  logic [DW-1:0] fa_s, fb_s;
  logic          load_use_s;

  // Forwarded value for one source register. EX/MEM is the younger result, so
  // it wins over MEM/WB. A load still in EX/MEM has no data yet and is skipped;
  // load_use keeps a dependent instruction out of this stage in that case.
  // Register 0 is hard-wired to zero and is never forwarded.
  function automatic logic [DW-1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic [DW-1:0] q,
    input logic          mw,
    input logic          mm2,
    input logic [AW-1:0] mrn,
    input logic [DW-1:0] malu,
    input logic          ww,
    input logic [AW-1:0] wrn,
    input logic [DW-1:0] wdat
  );
    logic [DW-1:0] res;
    res = q;
    if (mw && !mm2 && (mrn != {AW{1'b0}}) && (mrn == src)) begin
      res = malu;
    end else if (ww && (wrn != {AW{1'b0}}) && (wrn == src)) begin
      res = wdat;
    end else begin
      res = q;
    end
    return res;
  endfunction

  // Operand forwarding for rs and rt.
  always_comb begin
    fa_s = qa_r;
    fb_s = qb_r;
    fa_s = fwd_sel(rs_r, qa_r, m_wreg, m_m2reg, m_rn, m_alu, w_wreg, w_rn, w_data);
    fb_s = fwd_sel(rt_r, qb_r, m_wreg, m_m2reg, m_rn, m_alu, w_wreg, w_rn, w_data);
  end

  // Load-use hazard: a load held here feeds a register that decode reads.
  always_comb begin
    load_use_s = 1'b0;
    if (d_valid && valid_r && wreg_r && m2reg_r && (rn_r != {AW{1'b0}})) begin
      load_use_s = (d_use_rs && (d_rs == rn_r)) || (d_use_rt && (d_rt == rn_r));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Pipeline register. Priority: reset, flush, stall, load-use bubble, load.
  always_ff @(posedge clock) begin
    if (!resetn || flush || (!stall && load_use_s)) begin
      valid_r  <= 1'b0;
      rs_r     <= {AW{1'b0}};
      rt_r     <= {AW{1'b0}};
      rn_r     <= {AW{1'b0}};
      qa_r     <= {DW{1'b0}};
      qb_r     <= {DW{1'b0}};
      imm_r    <= {DW{1'b0}};
      sa_r     <= 5'd0;
      aluc_r   <= 4'd0;
      aluimm_r <= 1'b0;
      shift_r  <= 1'b0;
      wreg_r   <= 1'b0;
      m2reg_r  <= 1'b0;
      wmem_r   <= 1'b0;
    end else if (stall) begin
      // Capture write-backs that complete while held, so they are not lost
      // once the forwarding source moves on.
      qa_r <= fa_s;
      qb_r <= fb_s;
    end else begin
      valid_r  <= d_valid;
      rs_r     <= d_rs;
      rt_r     <= d_rt;
      rn_r     <= d_rn;
      qa_r     <= d_qa;
      qb_r     <= d_qb;
      imm_r    <= d_imm;
      sa_r     <= d_sa;
      aluc_r   <= d_aluc;
      aluimm_r <= d_aluimm;
      shift_r  <= d_shift;
      wreg_r   <= d_wreg;
      m2reg_r  <= d_m2reg;
      wmem_r   <= d_wmem;
    end
  end

  // ALU operand selection and gated controls.
  always_comb begin
    e_a = fa_s;
    e_b = fb_s;
    if (shift_r) begin
      e_a = fb_s;
      e_b = {{(DW-5){1'b0}}, sa_r};
    end else if (aluimm_r) begin
      e_a = fa_s;
      e_b = imm_r;
    end else begin
      e_a = fa_s;
      e_b = fb_s;
    end
  end

  assign e_store  = fb_s;
  assign e_aluc   = aluc_r;
  assign e_valid  = valid_r;
  assign e_wreg   = valid_r & wreg_r;
  assign e_m2reg  = valid_r & m2reg_r;
  assign e_wmem   = valid_r & wmem_r;
  assign e_rn     = rn_r;
  assign load_use = load_use_s;

endmodule
